// File: rtl/rv32_pkg.sv
// Shared definitions for the register-file writeback path: widths, the x0 index,
// the requester grant encoding and a population-count helper.
package rv32_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NREG = 1 << AW;
  localparam int CNTW = 6;

  localparam logic [AW-1:0] REG_X0 = '0;

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_LSU = 1'b1
  } grant_e;

  function automatic logic [CNTW-1:0] popcount(input logic [NREG-1:0] v);
    logic [CNTW-1:0] c;
    c = '0;
    for (int i = 0; i < NREG; i++) begin
      c = c + CNTW'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter (ALU vs LSU). A lone request is always granted;
// on a conflict the requester that did not win last time is granted.
module rr_arb2
  import rv32_pkg::*;
(
  input  logic CLK,
  input  logic RSTN,
  input  logic i_req_alu,
  input  logic i_req_lsu,
  output logic o_gnt_alu,
  output logic o_gnt_lsu
);

  grant_e r_last_grant;

  always_comb begin
    o_gnt_alu = i_req_alu & (~i_req_lsu | (r_last_grant == GNT_LSU));
    o_gnt_lsu = i_req_lsu & (~i_req_alu | (r_last_grant == GNT_ALU));
  end

  // Resetting to ALU makes the LSU win the first conflict after reset.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_last_grant <= GNT_ALU;
    end else if (o_gnt_alu) begin
      r_last_grant <= GNT_ALU;
    end else if (o_gnt_lsu) begin
      r_last_grant <= GNT_LSU;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port owner: round-robin between ALU and LSU writebacks,
// plus a load scoreboard that stalls decode on hazards against pending loads.
module rf_wb_arbiter
  import rv32_pkg::*;
(
  input  logic            CLK,
  input  logic            RSTN,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  input  logic            iss_valid,
  input  logic            iss_load,
  input  logic [AW-1:0]   iss_rd,
  input  logic [AW-1:0]   iss_rs1,
  input  logic [AW-1:0]   iss_rs2,
  output logic            iss_stall,
  input  logic            flush,
  output logic            rd_wen,
  output logic [AW-1:0]   rd,
  output logic [XLEN-1:0] rd_data,
  output logic [CNTW-1:0] busy_cnt
);

  logic            w_alu_gnt;
  logic            w_lsu_gnt;
  logic            w_alu_xfer;
  logic            w_lsu_xfer;
  logic            w_stall;
  logic            w_set_en;
  logic [NREG-1:0] w_set_mask;
  logic [NREG-1:0] w_clr_mask;
  logic [NREG-1:0] w_busy_next;

  logic            r_rd_wen;
  logic [AW-1:0]   r_rd;
  logic [XLEN-1:0] r_rd_data;
  logic [NREG-1:0] r_busy;
  logic [CNTW-1:0] r_busy_cnt;

  rr_arb2 u_arb (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .i_req_alu (alu_valid),
    .i_req_lsu (lsu_valid),
    .o_gnt_alu (w_alu_gnt),
    .o_gnt_lsu (w_lsu_gnt)
  );

  assign alu_ready  = w_alu_gnt;
  assign lsu_ready  = w_lsu_gnt;
  assign w_alu_xfer = alu_valid & w_alu_gnt;
  assign w_lsu_xfer = lsu_valid & w_lsu_gnt;

  // Stall looks only at the registered busy vector; a clear landing this cycle
  // releases the stall one cycle later.
  assign w_stall = iss_valid &
                   ((r_busy[iss_rs1] & (iss_rs1 != REG_X0)) |
                    (r_busy[iss_rs2] & (iss_rs2 != REG_X0)) |
                    (iss_load & r_busy[iss_rd] & (iss_rd != REG_X0)));
  assign iss_stall = w_stall;

  assign w_set_en = iss_valid & iss_load & ~w_stall & (iss_rd != REG_X0);

  for (genvar gi = 0; gi < NREG; gi++) begin : g_sb
    assign w_set_mask[gi] = w_set_en & (iss_rd == AW'(gi));
    assign w_clr_mask[gi] = w_lsu_xfer & (lsu_rd == AW'(gi));
  end

  // Set is ORed in after the clear so a same-register set wins; flush beats both.
  always_comb begin
    w_busy_next = (r_busy & ~w_clr_mask) | w_set_mask;
    w_busy_next[0] = 1'b0;
    if (flush) begin
      w_busy_next = '0;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_next;
      r_busy_cnt <= popcount(w_busy_next);
    end
  end

  // Idle and x0 cycles drive index/data to zero: the RF bypass compares rs==rd
  // without looking at the write enable.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_rd_wen  <= 1'b0;
      r_rd      <= '0;
      r_rd_data <= '0;
    end else if (w_alu_xfer && (alu_rd != REG_X0)) begin
      r_rd_wen  <= 1'b1;
      r_rd      <= alu_rd;
      r_rd_data <= alu_data;
    end else if (w_lsu_xfer && (lsu_rd != REG_X0)) begin
      r_rd_wen  <= 1'b1;
      r_rd      <= lsu_rd;
      r_rd_data <= lsu_data;
    end else begin
      r_rd_wen  <= 1'b0;
      r_rd      <= '0;
      r_rd_data <= '0;
    end
  end

  assign rd_wen   = r_rd_wen;
  assign rd       = r_rd;
  assign rd_data  = r_rd_data;
  assign busy_cnt = r_busy_cnt;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: directed vectors push expected writes,
// a negedge monitor pops and compares every register-file write.
module tb_rf_wb_arbiter;

  logic        CLK;
  logic        RSTN;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        iss_valid;
  logic        iss_load;
  logic [4:0]  iss_rd;
  logic [4:0]  iss_rs1;
  logic [4:0]  iss_rs2;
  logic        iss_stall;
  logic        flush;
  logic        rd_wen;
  logic [4:0]  rd;
  logic [31:0] rd_data;
  logic [5:0]  busy_cnt;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;

  rf_wb_arbiter dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .lsu_valid (lsu_valid),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .lsu_ready (lsu_ready),
    .iss_valid (iss_valid),
    .iss_load  (iss_load),
    .iss_rd    (iss_rd),
    .iss_rs1   (iss_rs1),
    .iss_rs2   (iss_rs2),
    .iss_stall (iss_stall),
    .flush     (flush),
    .rd_wen    (rd_wen),
    .rd        (rd),
    .rd_data   (rd_data),
    .busy_cnt  (busy_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [4:0] r, input logic [31:0] d);
    wr_t e;
    e.rd   = r;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  // Monitor: every write-port event pops one expected write; idle cycles must be all-zero.
  initial begin
    wr_t e;
    forever begin
      @(negedge CLK);
      if (RSTN === 1'b1) begin
        if (rd_wen === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_write: got rd=%0d data=0x%0h, expected no write", rd, rd_data);
          end else begin
            e = exp_q.pop_front();
            chk("wb_rd", 32'(rd), 32'(e.rd));
            chk("wb_data", rd_data, e.data);
            $display("write rd=%0d data=0x%08h (expected rd=%0d data=0x%08h)", rd, rd_data, e.rd, e.data);
          end
        end else begin
          chk("idle_wen", 32'(rd_wen), 32'd0);
          chk("idle_rd", 32'(rd), 32'd0);
          chk("idle_data", rd_data, 32'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    iss_valid = 0; iss_load = 0; iss_rd = 0; iss_rs1 = 0; iss_rs2 = 0;
    flush = 0;
    RSTN = 1'b1;
    #1 RSTN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_wen", 32'(rd_wen), 32'd0);
    chk("reset_rd", 32'(rd), 32'd0);
    chk("reset_data", rd_data, 32'd0);
    chk("reset_busy_cnt", 32'(busy_cnt), 32'd0);
    @(negedge CLK);
    RSTN = 1'b1;

    // Both valid from reset: LSU first, ALU next.
    tick();
    alu_valid = 1; alu_rd = 5'd3; alu_data = 32'hAAAA_0003;
    lsu_valid = 1; lsu_rd = 5'd4; lsu_data = 32'h4444_0004;
    expect_wr(5'd4, 32'h4444_0004);
    sample();
    chk("t2_lsu_ready_c0", 32'(lsu_ready), 32'd1);
    chk("t2_alu_ready_c0", 32'(alu_ready), 32'd0);
    tick();
    lsu_valid = 0;
    expect_wr(5'd3, 32'hAAAA_0003);
    sample();
    chk("t2_alu_ready_c1", 32'(alu_ready), 32'd1);
    chk("t2_lsu_ready_c1", 32'(lsu_ready), 32'd0);

    // ALU only.
    tick();
    alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
    expect_wr(5'd5, 32'hDEAD_BEEF);
    sample();
    chk("t1_alu_ready", 32'(alu_ready), 32'd1);
    tick();
    alu_valid = 0;

    // Load scoreboard RAW/WAW stall on x7.
    iss_valid = 1; iss_load = 1; iss_rd = 5'd7; iss_rs1 = 0; iss_rs2 = 0;
    sample();
    chk("t3_load_issue_stall", 32'(iss_stall), 32'd0);
    chk("t3_cnt_before", 32'(busy_cnt), 32'd0);
    tick();
    iss_load = 0; iss_rd = 5'd8; iss_rs1 = 5'd7;
    sample();
    chk("t3_raw_stall", 32'(iss_stall), 32'd1);
    chk("t3_cnt_set", 32'(busy_cnt), 32'd1);
    tick();
    iss_load = 1; iss_rd = 5'd7; iss_rs1 = 0;
    sample();
    chk("t3_waw_stall", 32'(iss_stall), 32'd1);
    tick();
    iss_load = 0; iss_rd = 5'd8; iss_rs2 = 5'd7;
    lsu_valid = 1; lsu_rd = 5'd7; lsu_data = 32'h7777_C0DE;
    expect_wr(5'd7, 32'h7777_C0DE);
    sample();
    chk("t3_lsu_ready", 32'(lsu_ready), 32'd1);
    chk("t3_stall_no_bypass", 32'(iss_stall), 32'd1);
    chk("t3_cnt_held", 32'(busy_cnt), 32'd1);
    tick();
    lsu_valid = 0;
    sample();
    chk("t3_stall_released", 32'(iss_stall), 32'd0);
    chk("t3_cnt_cleared", 32'(busy_cnt), 32'd0);
    tick();
    iss_valid = 0; iss_rs2 = 0;

    // Writes to x0 are accepted but never reach the port.
    alu_valid = 1; alu_rd = 5'd0; alu_data = 32'h1234_5678;
    sample();
    chk("t4_alu_ready", 32'(alu_ready), 32'd1);
    tick();
    alu_valid = 0;
    lsu_valid = 1; lsu_rd = 5'd0; lsu_data = 32'h8765_4321;
    sample();
    chk("t4_lsu_ready", 32'(lsu_ready), 32'd1);
    chk("t4_alu_x0_wen", 32'(rd_wen), 32'd0);
    chk("t4_alu_x0_data", rd_data, 32'd0);
    tick();
    lsu_valid = 0;
    sample();
    chk("t4_lsu_x0_wen", 32'(rd_wen), 32'd0);
    chk("t4_lsu_x0_rd", 32'(rd), 32'd0);

    // Same-register set/clear: set wins. Different registers: both apply. Then flush.
    tick();
    iss_valid = 1; iss_load = 1; iss_rd = 5'd9; iss_rs1 = 0; iss_rs2 = 0;
    lsu_valid = 1; lsu_rd = 5'd9; lsu_data = 32'h0000_0099;
    expect_wr(5'd9, 32'h0000_0099);
    sample();
    chk("t5_issue_stall", 32'(iss_stall), 32'd0);
    chk("t5_lsu_ready", 32'(lsu_ready), 32'd1);
    tick();
    lsu_valid = 0; iss_load = 0; iss_rd = 0; iss_rs1 = 5'd9;
    sample();
    chk("t5_set_wins_cnt", 32'(busy_cnt), 32'd1);
    chk("t5_set_wins_stall", 32'(iss_stall), 32'd1);
    tick();
    iss_load = 1; iss_rd = 5'd10; iss_rs1 = 0;
    lsu_valid = 1; lsu_rd = 5'd9; lsu_data = 32'h0000_0999;
    expect_wr(5'd9, 32'h0000_0999);
    sample();
    chk("t5_diff_stall", 32'(iss_stall), 32'd0);
    tick();
    lsu_valid = 0; iss_load = 0; iss_rd = 0; iss_rs1 = 5'd9; iss_rs2 = 5'd10;
    sample();
    chk("t5_diff_stall_x10", 32'(iss_stall), 32'd1);
    chk("t5_diff_cnt", 32'(busy_cnt), 32'd1);
    tick();
    iss_rs2 = 0;
    sample();
    chk("t5_x9_cleared", 32'(iss_stall), 32'd0);
    tick();
    iss_load = 1; iss_rd = 5'd11; iss_rs1 = 0; flush = 1;
    sample();
    chk("t5_flush_issue_stall", 32'(iss_stall), 32'd0);
    tick();
    flush = 0; iss_load = 0; iss_rd = 0; iss_rs1 = 5'd10; iss_rs2 = 5'd11;
    sample();
    chk("t5_flush_cnt", 32'(busy_cnt), 32'd0);
    chk("t5_flush_stall", 32'(iss_stall), 32'd0);
    tick();
    iss_valid = 0; iss_rs1 = 0; iss_rs2 = 0;

    // Reset while an LSU request is held.
    iss_valid = 1; iss_load = 1; iss_rd = 5'd13;
    lsu_valid = 1; lsu_rd = 5'd14; lsu_data = 32'hE0E0_000E;
    expect_wr(5'd14, 32'hE0E0_000E);
    sample();
    chk("t6_lsu_ready", 32'(lsu_ready), 32'd1);
    tick();
    iss_valid = 0; iss_load = 0; iss_rd = 0;
    expect_wr(5'd14, 32'hE0E0_000E);
    sample();
    chk("t6_cnt_before_reset", 32'(busy_cnt), 32'd1);
    #1 RSTN = 1'b0;
    #1;
    chk("t6_reset_wen", 32'(rd_wen), 32'd0);
    chk("t6_reset_rd", 32'(rd), 32'd0);
    chk("t6_reset_data", rd_data, 32'd0);
    chk("t6_reset_cnt", 32'(busy_cnt), 32'd0);
    @(posedge CLK);
    #3 RSTN = 1'b1;
    iss_valid = 1; iss_rs1 = 5'd13;
    sample();
    chk("t6_regrant_ready", 32'(lsu_ready), 32'd1);
    chk("t6_no_write_in_reset", 32'(rd_wen), 32'd0);
    chk("t6_scoreboard_cleared", 32'(iss_stall), 32'd0);
    tick();
    lsu_valid = 0; iss_valid = 0; iss_rs1 = 0;

    repeat (3) tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
